uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
Frame sequencer for the UART transmitter. It accepts a parallel word through a valid/ack handshake and latches it. It drives the parity calculator's enable and data inputs, then serialises start, data (LSB first), optional parity and stop bits onto TX_OUT. CLK is the transmit bit clock, so each bit lasts exactly one CLK cycle. It sits between the TX front end and the line, alongside the parity calculator.

Parameters:
DATA_WIDTH, 8, width of the parallel data word (legal range 5..9)
STOP_BITS, 1, number of stop-bit cycles per frame (1 or 2)

Ports:
CLK  input  1  transmit bit clock
RST  input  1  asynchronous active-low reset
P_DATA  input  DATA_WIDTH  parallel word to transmit
DATA_VALID  input  1  word on P_DATA is offered for transmission
PAR_EN  input  1  include a parity bit in the frame (sampled at accept)
DATA_ACK  output  1  word accepted this cycle (combinational)
par_calc_en  output  1  enable for the parity calculator
P_DATA_LAT  output  DATA_WIDTH  latched word, drives the parity calculator's P_DATA
par_bit  input  1  parity bit from the parity calculator
TX_OUT  output  1  serial line, idle high
Busy  output  1  frame in progress

Behaviour:
- Reset:
  - RST is asynchronous and active-low; clock is CLK.
  - Reset forces state to IDLE, shift register to 0, P_DATA_LAT to 0, bit counter to 0, stop counter to 0, and latched par_en to 0.
  - Outputs during and immediately after reset: TX_OUT=1, Busy=0, DATA_ACK=0, par_calc_en=0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Accept condition: DATA_ACK = DATA_VALID && (state==IDLE || (state==STOP && last stop cycle)).
- On an accept edge:
  - P_DATA is copied to P_DATA_LAT and to the shift register.
  - PAR_EN is latched.
  - Next state is START.
- Transitions:
  - IDLE: go to START on accept; otherwise hold.
  - START (1 cycle): go to DATA; bit counter cleared.
  - DATA (DATA_WIDTH cycles): shift right each cycle; counter increments. On the last bit go to PARITY if latched par_en=1, else to STOP.
  - PARITY (1 cycle): go to STOP.
  - STOP (STOP_BITS cycles): on the last stop cycle go to START if accepting, else to IDLE.
- TX_OUT is a combinational decode of state:
  - IDLE: 1.
  - START: 0.
  - DATA: shift register bit 0.
  - PARITY: par_bit.
  - STOP: 1.
- Busy = (state != IDLE).
- par_calc_en is high for exactly the START cycle. P_DATA_LAT is stable then, so par_bit is registered at the end of START and is valid well before PARITY.
- Latency: accept at edge k gives start bit in cycle k+1 and first data bit at k+2.
- Frame length: 1 + DATA_WIDTH + PAR + STOP_BITS cycles.
- Back-to-back: a word accepted on the last stop cycle starts its start bit on the very next cycle, with no idle gap.
- P_DATA and PAR_EN changes after accept have no effect on the current frame. DATA_VALID held high in non-accepting states is ignored, and DATA_ACK stays 0.
- Reset mid-frame: TX_OUT returns to 1 asynchronously and the frame is abandoned. Nothing resumes after reset release; the controller waits in IDLE for a new DATA_VALID.
- par_bit is never sampled outside PARITY.

Test Plan:
1. Reset: assert RST=0 mid-DATA of a frame -> TX_OUT=1, Busy=0 within the same cycle. After release, IDLE holds until DATA_VALID.
2. Even parity: DATA_WIDTH=8, P_DATA=0xA5, PAR_EN=1, parity calculator PAR_TYP=0, one-cycle DATA_VALID.
   - TX_OUT sequence: 0, then 1,0,1,0,0,1,0,1, then parity 0, then stop 1 (11 cycles).
   - Busy high for 11 cycles.
   - par_calc_en high exactly in the start-bit cycle.
3. Odd parity / no parity:
   - P_DATA=0xA5 with PAR_TYP=1 -> parity bit 1.
   - P_DATA=0x3C with PAR_EN=0 -> 10-cycle frame, TX_OUT 0, 0,0,1,1,1,1,0,0, 1.
4. Back-to-back: DATA_VALID held high with 0x01 then 0x80, PAR_EN=0 -> second start bit immediately follows the first stop bit. DATA_ACK pulses exactly twice, 10 cycles apart.
5. Busy ignore: change P_DATA to 0xFF and pulse DATA_VALID during DATA -> DATA_ACK=0 and the frame is still 0xA5.
6. STOP_BITS=2: P_DATA=0x00, PAR_EN=1, even parity -> parity 0 followed by two stop cycles of 1. The next accept is only possible on the second stop cycle.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
//
// Frame sequencer for the UART transmitter. A parallel word is accepted through
// a valid/ack handshake, latched, handed to the external parity calculator, and
// serialised onto the line as:
//   start(0), data bits LSB first, optional parity, STOP_BITS stop bits(1).
// CLK is the transmit bit clock, so every bit occupies exactly one CLK cycle.
//
// Parameters
//   DATA_WIDTH  width of the parallel word (5..9)
//   STOP_BITS   stop-bit cycles per frame (1 or 2)
//
// Ports
//   CLK          in   transmit bit clock
//   RST          in   asynchronous reset, active low
//   P_DATA       in   parallel word offered for transmission
//   DATA_VALID   in   P_DATA is offered this cycle
//   PAR_EN       in   include a parity bit (sampled on accept)
//   DATA_ACK     out  word accepted on the coming edge (combinational)
//   par_calc_en  out  parity calculator enable, high during the start bit
//   P_DATA_LAT   out  latched word feeding the parity calculator
//   par_bit      in   parity bit from the parity calculator
//   TX_OUT       out  serial line, idle high
//   Busy         out  a frame is in progress
// -----------------------------------------------------------------------------
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    output logic                  DATA_ACK,
    output logic                  par_calc_en,
    output logic [DATA_WIDTH-1:0] P_DATA_LAT,
    input  logic                  par_bit,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int               CNT_W     = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  stop_cnt;
    logic                  par_en_lat;
    logic                  last_stop;
    logic                  accept;

    // A new word may be taken while idle, or on the final stop cycle so that
    // back-to-back frames run without an idle gap.
    assign last_stop = (state == STOP) && (stop_cnt == LAST_STOP);
    assign accept    = DATA_VALID && ((state == IDLE) || last_stop);

    // Held low while reset is asserted so no handshake is reported then.
    assign DATA_ACK  = RST && accept;

    assign Busy        = (state != IDLE);
    assign par_calc_en = (state == START);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            shift_reg  <= '0;
            P_DATA_LAT <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            par_en_lat <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        P_DATA_LAT <= P_DATA;
                        shift_reg  <= P_DATA;
                        par_en_lat <= PAR_EN;
                        state      <= START;
                    end
                end

                START: begin
                    bit_cnt <= '0;
                    state   <= DATA;
                end

                DATA: begin
                    shift_reg <= shift_reg >> 1;
                    bit_cnt   <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        stop_cnt <= 1'b0;
                        state    <= par_en_lat ? PARITY : STOP;
                    end
                end

                PARITY: begin
                    stop_cnt <= 1'b0;
                    state    <= STOP;
                end

                STOP: begin
                    if (last_stop) begin
                        if (accept) begin
                            P_DATA_LAT <= P_DATA;
                            shift_reg  <= P_DATA;
                            par_en_lat <= PAR_EN;
                            state      <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        stop_cnt <= stop_cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // Line level is a pure decode of the state; an asynchronous reset forces
    // the state to IDLE and therefore the line high immediately. par_bit is
    // only looked at during PARITY.
    always_comb begin
        TX_OUT = 1'b1;
        case (state)
            IDLE:    TX_OUT = 1'b1;
            START:   TX_OUT = 1'b0;
            DATA:    TX_OUT = shift_reg[0];
            PARITY:  TX_OUT = par_bit;
            STOP:    TX_OUT = 1'b1;
            default: TX_OUT = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for uart_tx_ctrl. Two instances: dut1 with one stop bit and dut2
// with two stop bits. Each has a small parity-calculator model that registers
// ^P_DATA_LAT ^ par_typ while par_calc_en is high. Expected frames come from
// a bit-list model: start, data LSB first, optional parity, stop bits.
// -----------------------------------------------------------------------------
module tb_uart_tx_ctrl;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic par_typ = 1'b0;

    logic [7:0] p_data1 = '0;
    logic       valid1  = 1'b0;
    logic       pe1     = 1'b0;
    logic       ack1, pce1, pbit1, tx1, busy1;
    logic [7:0] lat1;

    logic [7:0] p_data2 = '0;
    logic       valid2  = 1'b0;
    logic       pe2     = 1'b0;
    logic       ack2, pce2, pbit2, tx2, busy2;
    logic [7:0] lat2;

    uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(1)) dut1 (
        .CLK(CLK), .RST(RST), .P_DATA(p_data1), .DATA_VALID(valid1),
        .PAR_EN(pe1), .DATA_ACK(ack1), .par_calc_en(pce1),
        .P_DATA_LAT(lat1), .par_bit(pbit1), .TX_OUT(tx1), .Busy(busy1)
    );

    uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(2)) dut2 (
        .CLK(CLK), .RST(RST), .P_DATA(p_data2), .DATA_VALID(valid2),
        .PAR_EN(pe2), .DATA_ACK(ack2), .par_calc_en(pce2),
        .P_DATA_LAT(lat2), .par_bit(pbit2), .TX_OUT(tx2), .Busy(busy2)
    );

    always #5 CLK = ~CLK;

    // Parity calculator models (PAR_TYP: 0 even, 1 odd).
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)      pbit1 <= 1'b0;
        else if (pce1) pbit1 <= (^lat1) ^ par_typ;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)      pbit2 <= 1'b0;
        else if (pce2) pbit2 <= (^lat2) ^ par_typ;
    end

    int total = 0;
    int bad   = 0;

    bit         exp_q[$];
    logic       obs_tx[$];
    logic       obs_busy[$];
    logic       obs_pce[$];
    logic       obs_ack[$];
    logic [7:0] obs_lat[$];

    // Expected line bits of one frame, appended to exp_q.
    function automatic void model_frame(input logic [7:0] d, input logic pe,
                                        input logic typ, input int stops);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (pe) exp_q.push_back((^d) ^ typ);
        for (int i = 0; i < stops; i++) exp_q.push_back(1'b1);
    endfunction

    // Record n cycles of outputs from one instance, sampled on the falling edge.
    task automatic capture(input int which, input int n);
        obs_tx.delete(); obs_busy.delete(); obs_pce.delete();
        obs_ack.delete(); obs_lat.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            if (which == 1) begin
                obs_tx.push_back(tx1);   obs_busy.push_back(busy1);
                obs_pce.push_back(pce1); obs_ack.push_back(ack1);
                obs_lat.push_back(lat1);
            end else begin
                obs_tx.push_back(tx2);   obs_busy.push_back(busy2);
                obs_pce.push_back(pce2); obs_ack.push_back(ack2);
                obs_lat.push_back(lat2);
            end
        end
    endtask

    // Offer one word to dut1 for a single cycle; called just after a rising edge.
    task automatic offer1(input logic [7:0] d, input logic pe, output logic ack_seen);
        p_data1 = d;
        pe1     = pe;
        valid1  = 1'b1;
        @(negedge CLK);
        ack_seen = ack1;
        @(posedge CLK);
        #1 valid1 = 1'b0;
    endtask

    task automatic test_reset();
        logic a;
        #1 RST = 1'b0;
        #1;
        total++;
        if ({tx1, busy1, ack1, pce1, lat1} !== {4'b1000, 8'h00}) begin
            bad++;
            $display("FAIL reset_dut1 {tx,busy,ack,pce,lat} got=%b want=%b",
                     {tx1, busy1, ack1, pce1, lat1}, {4'b1000, 8'h00});
        end
        total++;
        if ({tx2, busy2, ack2, pce2, lat2} !== {4'b1000, 8'h00}) begin
            bad++;
            $display("FAIL reset_dut2 {tx,busy,ack,pce,lat} got=%b want=%b",
                     {tx2, busy2, ack2, pce2, lat2}, {4'b1000, 8'h00});
        end
        @(negedge CLK); @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            total++;
            if ({tx1, busy1, ack1, pce1} !== 4'b1000) begin
                bad++;
                $display("FAIL post_reset[%0d] {tx,busy,ack,pce} got=%b want=1000",
                         i, {tx1, busy1, ack1, pce1});
            end
        end

        // Abandon a frame mid-DATA: the line must return high without a clock.
        par_typ = 1'b0;
        @(posedge CLK); #1;
        offer1(8'hA5, 1'b1, a);
        total++;
        if (a !== 1'b1) begin
            bad++;
            $display("FAIL midreset_ack got=%b want=1", a);
        end
        capture(1, 5);
        total++;
        if ({obs_tx[4], obs_busy[4]} !== 2'b01) begin
            bad++;
            $display("FAIL midreset_bit3 {tx,busy} got=%b want=01", {obs_tx[4], obs_busy[4]});
        end
        #2 RST = 1'b0;
        #1;
        total++;
        if ({tx1, busy1, pce1, lat1} !== {3'b100, 8'h00}) begin
            bad++;
            $display("FAIL midreset_async {tx,busy,pce,lat} got=%b want=%b",
                     {tx1, busy1, pce1, lat1}, {3'b100, 8'h00});
        end
        @(posedge CLK); @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            total++;
            if ({tx1, busy1} !== 2'b10) begin
                bad++;
                $display("FAIL midreset_idle[%0d] {tx,busy} got=%b want=10", i, {tx1, busy1});
            end
        end
    endtask

    task automatic test_even_parity();
        logic a;
        par_typ = 1'b0;
        @(posedge CLK); #1;
        offer1(8'hA5, 1'b1, a);
        total++;
        if (a !== 1'b1) begin
            bad++;
            $display("FAIL even_ack got=%b want=1", a);
        end
        exp_q.delete();
        model_frame(8'hA5, 1'b1, 1'b0, 1);
        capture(1, exp_q.size() + 1);
        total++;
        if (obs_lat[0] !== 8'hA5) begin
            bad++;
            $display("FAIL even_lat got=%h want=a5", obs_lat[0]);
        end
        for (int i = 0; i < exp_q.size() + 1; i++) begin
            logic [2:0] w, g;
            w = {(i < exp_q.size()) ? exp_q[i] : 1'b1, i < exp_q.size(), i == 0};
            g = {obs_tx[i], obs_busy[i], obs_pce[i]};
            total++;
            if (g !== w) begin
                bad++;
                $display("FAIL even[%0d] {tx,busy,pce} got=%b want=%b", i, g, w);
            end
        end
    endtask

    task automatic test_odd_parity();
        logic a;
        par_typ = 1'b1;
        @(posedge CLK); #1;
        offer1(8'hA5, 1'b1, a);
        exp_q.delete();
        model_frame(8'hA5, 1'b1, 1'b1, 1);
        capture(1, exp_q.size() + 1);
        total++;
        if ({a, obs_tx[9]} !== 2'b11) begin
            bad++;
            $display("FAIL odd_parity {ack,parbit} got=%b want=11", {a, obs_tx[9]});
        end
        for (int i = 0; i < exp_q.size() + 1; i++) begin
            logic [2:0] w, g;
            w = {(i < exp_q.size()) ? exp_q[i] : 1'b1, i < exp_q.size(), i == 0};
            g = {obs_tx[i], obs_busy[i], obs_pce[i]};
            total++;
            if (g !== w) begin
                bad++;
                $display("FAIL odd[%0d] {tx,busy,pce} got=%b want=%b", i, g, w);
            end
        end
        par_typ = 1'b0;
    endtask

    task automatic test_no_parity();
        logic a;
        @(posedge CLK); #1;
        offer1(8'h3C, 1'b0, a);
        exp_q.delete();
        model_frame(8'h3C, 1'b0, 1'b0, 1);
        capture(1, exp_q.size() + 1);
        total++;
        if (a !== 1'b1) begin
            bad++;
            $display("FAIL nopar_ack got=%b want=1", a);
        end
        for (int i = 0; i < exp_q.size() + 1; i++) begin
            logic [2:0] w, g;
            w = {(i < exp_q.size()) ? exp_q[i] : 1'b1, i < exp_q.size(), i == 0};
            g = {obs_tx[i], obs_busy[i], obs_pce[i]};
            total++;
            if (g !== w) begin
                bad++;
                $display("FAIL nopar[%0d] {tx,busy,pce} got=%b want=%b", i, g, w);
            end
        end
    endtask

    task automatic test_back_to_back();
        int ack_idx[$];
        logic first_ack;
        @(posedge CLK); #1;
        p_data1 = 8'h01; pe1 = 1'b0; valid1 = 1'b1;
        @(negedge CLK);
        first_ack = ack1;
        @(posedge CLK); #1;
        p_data1 = 8'h80;
        exp_q.delete();
        model_frame(8'h01, 1'b0, 1'b0, 1);
        model_frame(8'h80, 1'b0, 1'b0, 1);
        obs_tx.delete(); obs_busy.delete(); obs_pce.delete();
        for (int i = 0; i < exp_q.size() + 1; i++) begin
            @(negedge CLK);
            obs_tx.push_back(tx1); obs_busy.push_back(busy1); obs_pce.push_back(pce1);
            if (ack1) begin
                ack_idx.push_back(i);
                @(posedge CLK);
                #1 valid1 = 1'b0;
            end
        end
        valid1 = 1'b0;
        total++;
        if (first_ack !== 1'b1 || ack_idx.size() != 1 || (ack_idx.size() == 1 && ack_idx[0] != 9)) begin
            bad++;
            $display("FAIL b2b_acks first=%b later_count=%0d later_at=%0d want first=1 count=1 at=9",
                     first_ack, ack_idx.size(), (ack_idx.size() > 0) ? ack_idx[0] : -1);
        end
        for (int i = 0; i < exp_q.size() + 1; i++) begin
            logic [2:0] w, g;
            w = {(i < exp_q.size()) ? exp_q[i] : 1'b1, i < exp_q.size(), (i == 0) || (i == 10)};
            g = {obs_tx[i], obs_busy[i], obs_pce[i]};
            total++;
            if (g !== w) begin
                bad++;
                $display("FAIL b2b[%0d] {tx,busy,pce} got=%b want=%b", i, g, w);
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic a;
        int   acks;
        par_typ = 1'b0;
        @(posedge CLK); #1;
        offer1(8'hA5, 1'b1, a);
        exp_q.delete();
        model_frame(8'hA5, 1'b1, 1'b0, 1);
        obs_tx.delete(); obs_busy.delete(); obs_pce.delete();
        acks = 0;
        for (int i = 0; i < exp_q.size() + 1; i++) begin
            @(negedge CLK);
            obs_tx.push_back(tx1); obs_busy.push_back(busy1); obs_pce.push_back(pce1);
            if (ack1) acks++;
            if (i == 2) begin
                valid1 = 1'b1; p_data1 = 8'hFF; pe1 = 1'b0;
            end
            if (i == 6) valid1 = 1'b0;
        end
        total++;
        if ({a, acks != 0} !== 2'b10) begin
            bad++;
            $display("FAIL ignore_ack first=%b later_acks=%0d want first=1 later=0", a, acks);
        end
        for (int i = 0; i < exp_q.size() + 1; i++) begin
            logic [2:0] w, g;
            w = {(i < exp_q.size()) ? exp_q[i] : 1'b1, i < exp_q.size(), i == 0};
            g = {obs_tx[i], obs_busy[i], obs_pce[i]};
            total++;
            if (g !== w) begin
                bad++;
                $display("FAIL ignore[%0d] {tx,busy,pce} got=%b want=%b", i, g, w);
            end
        end
    endtask

    task automatic test_stop2();
        logic a;
        par_typ = 1'b0;
        @(posedge CLK); #1;
        p_data2 = 8'h00; pe2 = 1'b1; valid2 = 1'b1;
        @(negedge CLK);
        a = ack2;
        @(posedge CLK);
        #1 valid2 = 1'b0;
        total++;
        if (a !== 1'b1) begin
            bad++;
            $display("FAIL stop2_ack got=%b want=1", a);
        end
        exp_q.delete();
        model_frame(8'h00, 1'b1, 1'b0, 2);
        obs_tx.delete(); obs_busy.delete(); obs_pce.delete(); obs_ack.delete();
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge CLK);
            obs_tx.push_back(tx2); obs_busy.push_back(busy2);
            obs_pce.push_back(pce2); obs_ack.push_back(ack2);
            if (i == 4) begin
                valid2 = 1'b1; p_data2 = 8'h5A; pe2 = 1'b0;
            end
            if (ack2) begin
                @(posedge CLK);
                #1 valid2 = 1'b0;
            end
        end
        valid2 = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [3:0] w, g;
            w = {exp_q[i], 1'b1, i == 0, i == exp_q.size() - 1};
            g = {obs_tx[i], obs_busy[i], obs_pce[i], obs_ack[i]};
            total++;
            if (g !== w) begin
                bad++;
                $display("FAIL stop2_f1[%0d] {tx,busy,pce,ack} got=%b want=%b", i, g, w);
            end
        end
        exp_q.delete();
        model_frame(8'h5A, 1'b0, 1'b0, 2);
        capture(2, exp_q.size() + 1);
        for (int i = 0; i < exp_q.size() + 1; i++) begin
            logic [2:0] w, g;
            w = {(i < exp_q.size()) ? exp_q[i] : 1'b1, i < exp_q.size(), i == 0};
            g = {obs_tx[i], obs_busy[i], obs_pce[i]};
            total++;
            if (g !== w) begin
                bad++;
                $display("FAIL stop2_f2[%0d] {tx,busy,pce} got=%b want=%b", i, g, w);
            end
        end
    endtask

    task automatic test_random();
        logic       a;
        logic [7:0] d;
        logic       pe;
        for (int f = 0; f < 16; f++) begin
            d       = 8'($urandom);
            pe      = 1'($urandom_range(0, 1));
            par_typ = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) @(posedge CLK);
            @(posedge CLK); #1;
            offer1(d, pe, a);
            // Inputs wander after the accept; the frame must not notice.
            p_data1 = 8'($urandom);
            pe1     = 1'($urandom_range(0, 1));
            exp_q.delete();
            model_frame(d, pe, par_typ, 1);
            capture(1, exp_q.size() + 1);
            total++;
            if (a !== 1'b1) begin
                bad++;
                $display("FAIL rand[%0d]_ack got=%b want=1", f, a);
            end
            for (int i = 0; i < exp_q.size() + 1; i++) begin
                logic [2:0] w, g;
                w = {(i < exp_q.size()) ? exp_q[i] : 1'b1, i < exp_q.size(), i == 0};
                g = {obs_tx[i], obs_busy[i], obs_pce[i]};
                total++;
                if (g !== w) begin
                    bad++;
                    $display("FAIL rand[%0d][%0d] data=%h pe=%b typ=%b {tx,busy,pce} got=%b want=%b",
                             f, i, d, pe, par_typ, g, w);
                end
            end
        end
        par_typ = 1'b0;
    endtask

    initial begin
        test_reset();
        test_even_parity();
        test_odd_parity();
        test_no_parity();
        test_back_to_back();
        test_busy_ignore();
        test_stop2();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
